// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 vector datapath units.
// Holds lane geometry, accumulator width, VDOT FSM state encoding,
// saturation bounds and a lane-select helper.
package cvp14_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned LW    = 16;
  // 2*LW product bits plus log2(LANES) guard bits so the sum never wraps.
  localparam int unsigned ACCW  = 36;
  localparam int unsigned CNTW  = $clog2(LANES);
  localparam int unsigned VW    = LANES * LW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [LW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [LW-1:0] SAT_MIN = 16'h8000;

  // Lane idx of a packed vector; lane i occupies bits [LW*i +: LW].
  function automatic logic [LW-1:0] lane_sel(input logic [VW-1:0]   vec,
                                             input logic [CNTW-1:0] idx);
    return vec[idx*LW +: LW];
  endfunction

endpackage

// File: rtl/vdot16_mac.sv
// One multiply-accumulate step of the VDOT unit (purely combinational).
// Ports:
//   lane_a_i, lane_b_i : signed LW-bit lane operands
//   acc_i              : current accumulator (signed, ACCW bits)
//   acc_o              : acc_i + sign-extended lane_a_i * lane_b_i
//   sat_o              : acc_o saturated to a signed LW-bit value
//   ovf_o              : acc_o lies outside the signed LW-bit range
module vdot16_mac
  import cvp14_pkg::*;
(
  input  logic [LW-1:0]   lane_a_i,
  input  logic [LW-1:0]   lane_b_i,
  input  logic [ACCW-1:0] acc_i,
  output logic [ACCW-1:0] acc_o,
  output logic [LW-1:0]   sat_o,
  output logic            ovf_o
);

  localparam logic signed [ACCW-1:0] SumMax = {{(ACCW-LW){1'b0}}, SAT_MAX};
  localparam logic signed [ACCW-1:0] SumMin = {{(ACCW-LW){1'b1}}, SAT_MIN};

  logic signed [2*LW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;

  assign prod     = $signed(lane_a_i) * $signed(lane_b_i);
  assign prod_ext = {{(ACCW-2*LW){prod[2*LW-1]}}, prod};
  assign sum      = $signed(acc_i) + prod_ext;
  assign acc_o    = sum;

  always_comb begin
    sat_o = sum[LW-1:0];
    ovf_o = 1'b0;
    if (sum > SumMax) begin
      sat_o = SAT_MAX;
      ovf_o = 1'b1;
    end else if (sum < SumMin) begin
      sat_o = SAT_MIN;
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/vdot16.sv
// Sequential 16-lane signed dot product for the CVP14 VDOT opcode.
// One lane is multiplied and accumulated per cycle; the result is saturated
// to 16 bits. Uses the same level start / held done handshake as VADD16.
// Ports:
//   Clk     : clock, all state on rising edge
//   Reset   : synchronous active-high reset
//   Inval1  : operand A, lane i = bits [16i+15:16i]
//   Inval2  : operand B, same layout
//   start   : level request, held until done is seen
//   done    : result valid, held until start is sampled low
//   DotOut  : saturated signed dot product
//   Overflw : exact sum was outside the signed 16-bit range
module vdot16
  import cvp14_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic [VW-1:0] Inval1,
  input  logic [VW-1:0] Inval2,
  input  logic          start,
  output logic          done,
  output logic [LW-1:0] DotOut,
  output logic          Overflw
);

  state_e          state_q, state_d;
  logic [VW-1:0]   opa_q, opa_d;
  logic [VW-1:0]   opb_q, opb_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [LW-1:0]   dot_q, dot_d;
  logic            ovf_q, ovf_d;

  logic [ACCW-1:0] mac_acc;
  logic [LW-1:0]   mac_sat;
  logic            mac_ovf;

  vdot16_mac u_mac (
    .lane_a_i (lane_sel(opa_q, cnt_q)),
    .lane_b_i (lane_sel(opb_q, cnt_q)),
    .acc_i    (acc_q),
    .acc_o    (mac_acc),
    .sat_o    (mac_sat),
    .ovf_o    (mac_ovf)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    dot_d   = dot_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        // Operands are captured only here; later input changes are ignored.
        if (start) begin
          opa_d   = Inval1;
          opb_d   = Inval2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = mac_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(LANES - 1)) begin
          dot_d   = mac_sat;
          ovf_d   = mac_ovf;
          done_d  = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        // A low phase on start is required before the next operation.
        if (!start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dot_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dot_q   <= dot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign done    = done_q;
  assign DotOut  = dot_q;
  assign Overflw = ovf_q;

endmodule
